// File: rtl/wots_chain_f.sv
// WOTS+ chain engine: applies the F tweakable hash to one chain value over a clamped
// position range, stamping the current index into the hash-address word before each call.
module wots_chain_f #(
  parameter int KEY_LEN        = 256,
  parameter int W              = 16,
  parameter int LOG_W          = 4,
  parameter int HASH_FIELD_LSB = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] input_key,
  input  logic [KEY_LEN-1:0] input_data,
  input  logic [255:0]       hash_addr,
  input  logic [LOG_W-1:0]   chain_start,
  input  logic [LOG_W-1:0]   chain_steps,
  output logic [KEY_LEN-1:0] data_out,
  output logic               busy,
  output logic               done,
  output logic               f_start,
  output logic [KEY_LEN-1:0] f_input_key,
  output logic [KEY_LEN-1:0] f_input_data,
  output logic [255:0]       f_hash_addr,
  input  logic               f_done,
  input  logic [KEY_LEN-1:0] f_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [LOG_W:0] LAST_POS = (LOG_W + 1)'(W - 1);

  logic [1:0]         state;
  logic [KEY_LEN-1:0] key_q;
  logic [KEY_LEN-1:0] work_q;
  logic [255:0]       addr_q;
  logic [LOG_W:0]     idx_q;
  logic [LOG_W:0]     end_q;

  logic [LOG_W:0]     pos_sum;
  logic [LOG_W:0]     end_c;
  logic [LOG_W:0]     idx_next;

  // One extra bit on the sum so start+steps cannot wrap before the clamp.
  always_comb begin
    pos_sum  = {1'b0, chain_start} + {1'b0, chain_steps};
    end_c    = (pos_sum > LAST_POS) ? LAST_POS : pos_sum;
    idx_next = idx_q + 1'b1;
  end

  always_comb begin
    f_hash_addr = addr_q;
    f_hash_addr[HASH_FIELD_LSB +: 32] = 32'(idx_q);
  end

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FIN);
  assign f_start      = (state == S_ISSUE);
  assign f_input_key  = key_q;
  assign f_input_data = work_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      key_q    <= '0;
      work_q   <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      end_q    <= '0;
      data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q  <= input_key;
            addr_q <= hash_addr;
            work_q <= input_data;
            idx_q  <= {1'b0, chain_start};
            end_q  <= end_c;
            if ({1'b0, chain_start} < end_c) begin
              state <= S_ISSUE;
            end else begin
              state    <= S_FIN;
              data_out <= input_data;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // data_out is loaded on the last return so it is already valid in FIN.
          if (f_done) begin
            work_q <= f_data_out;
            idx_q  <= idx_next;
            if (idx_next == end_q) begin
              state    <= S_FIN;
              data_out <= f_data_out;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wots_chain_f.sv
// Bench for wots_chain_f: mock F core (data ^ hash field, programmable latency) and
// a scoreboard of expected chain results popped when done is seen.
module tb_wots_chain_f;

  localparam int KEY_LEN = 256;
  localparam int W       = 16;
  localparam int LOG_W   = 4;
  localparam logic [255:0] FMASK = {192'd0, 32'hFFFF_FFFF, 32'd0};

  typedef struct {
    logic [255:0] dat;
    int           calls;
    int           lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [KEY_LEN-1:0] input_key = '0;
  logic [KEY_LEN-1:0] input_data = '0;
  logic [255:0]       hash_addr = '0;
  logic [LOG_W-1:0]   chain_start = '0;
  logic [LOG_W-1:0]   chain_steps = '0;
  logic [KEY_LEN-1:0] data_out;
  logic               busy;
  logic               done;
  logic               f_start;
  logic [KEY_LEN-1:0] f_input_key;
  logic [KEY_LEN-1:0] f_input_data;
  logic [255:0]       f_hash_addr;
  logic               f_done = 1'b0;
  logic [KEY_LEN-1:0] f_data_out = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  exp_t sb[$];

  // Mock-core controls (written by the stimulus process only).
  int  cur_start = 0;
  int  la = 1;
  int  lb = 1;
  bit  spur_req = 1'b0;

  // Mock-core state.
  int           mock_cnt = 0;
  logic [255:0] mock_val = '0;
  int           mk, ml;

  logic [255:0] cur_key, cur_addr, last_out;

  wots_chain_f #(.KEY_LEN(KEY_LEN), .W(W), .LOG_W(LOG_W), .HASH_FIELD_LSB(32)) dut (
    .clk(clk), .reset(reset), .start(start), .input_key(input_key),
    .input_data(input_data), .hash_addr(hash_addr), .chain_start(chain_start),
    .chain_steps(chain_steps), .data_out(data_out), .busy(busy), .done(done),
    .f_start(f_start), .f_input_key(f_input_key), .f_input_data(f_input_data),
    .f_hash_addr(f_hash_addr), .f_done(f_done), .f_data_out(f_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock F core: returns input ^ hash field after L cycles; latency alternates la/lb per call.
  always @(posedge clk) begin
    f_done <= 1'b0;
    if (spur_req) begin
      f_done     <= 1'b1;
      f_data_out <= '1;
    end else if (mock_cnt > 0) begin
      mock_cnt <= mock_cnt - 1;
      if (mock_cnt == 1) begin
        f_done     <= 1'b1;
        f_data_out <= mock_val;
      end
    end else if (f_start) begin
      mk = int'(f_hash_addr[63:32]) - cur_start;
      ml = (mk % 2 == 0) ? la : lb;
      if (ml <= 1) begin
        f_done     <= 1'b1;
        f_data_out <= f_input_data ^ 256'(f_hash_addr[63:32]);
      end else begin
        mock_cnt <= ml - 1;
        mock_val <= f_input_data ^ 256'(f_hash_addr[63:32]);
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_job(input int s, input int n, input logic [255:0] d,
                         input int la_i, input int lb_i, input bit glitch, input int abort_at);
    exp_t         rec;
    int           e, cyc0, n_calls, idx_e, stable_bad;
    bit           seen, in_wait;
    logic [255:0] work, h_addr, h_data, h_key;
    e = (s + n > W - 1) ? W - 1 : s + n;
    rec.dat = d; rec.calls = 0; rec.lat = 1;
    for (int i = s; i < e; i++) begin
      rec.dat ^= 256'(i);
      rec.lat += (((i - s) % 2 == 0) ? la_i : lb_i) + 1;
      rec.calls++;
    end
    sb.push_back(rec);
    cur_start = s; la = la_i; lb = lb_i;
    cur_key = rnd256(); cur_addr = rnd256();
    input_key = cur_key; hash_addr = cur_addr; input_data = d;
    chain_start = LOG_W'(s); chain_steps = LOG_W'(n);
    start = 1'b1;
    cyc0 = cyc;
    n_calls = 0; idx_e = s; work = d; stable_bad = 0; seen = 1'b0; in_wait = 1'b0;
    h_addr = '0; h_data = '0; h_key = '0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (glitch && t == 2) begin
        start = 1'b1; input_data = ~d; input_key = ~cur_key; hash_addr = ~cur_addr;
        chain_start = '0; chain_steps = LOG_W'(W - 1);
      end else begin
        start = 1'b0;
      end
      if (f_start) begin
        chk("f_field", 256'(f_hash_addr[63:32]), 256'(idx_e));
        chk("f_addr_rest", f_hash_addr & ~FMASK, cur_addr & ~FMASK);
        chk("f_data_in", f_input_data, work);
        chk("f_key", f_input_key, cur_key);
        h_addr = f_hash_addr; h_data = f_input_data; h_key = f_input_key;
        work ^= 256'(idx_e);
        idx_e++; n_calls++; in_wait = 1'b1;
      end else if (in_wait) begin
        if (f_hash_addr !== h_addr || f_input_data !== h_data || f_input_key !== h_key)
          stable_bad++;
        if (f_done) in_wait = 1'b0;
        if (abort_at > 0 && n_calls == abort_at) return;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 256'(1), 256'(0));
        end else begin
          rec = sb.pop_front();
          chk("data_out", data_out, rec.dat);
          chk("call_count", 256'(n_calls), 256'(rec.calls));
          chk("latency", 256'(cyc - cyc0), 256'(rec.lat));
          chk("wait_stable", 256'(stable_bad), 256'(0));
          last_out = rec.dat;
        end
        seen = 1'b1;
      end
    end
    if (!seen) begin
      chk("done_timeout", 256'(0), 256'(1));
      return;
    end
    @(negedge clk);
    chk("done_pulse", 256'(done), 256'(0));
    chk("busy_fall", 256'(busy), 256'(0));
  endtask

  initial begin
    int n_done;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_f_start", 256'(f_start), 256'(0));
    chk("rst_data_out", data_out, 256'(0));
    reset = 1'b0;
    @(negedge clk);

    run_job(0, 15, rnd256(), 1, 1, 1'b0, 0);             // full chain
    run_job(5, 0, {32{8'hA5}}, 1, 1, 1'b0, 0);           // zero steps
    run_job(10, 10, rnd256(), 2, 3, 1'b0, 0);            // clamp to 5 calls
    run_job(3, 4, rnd256(), 1, 100, 1'b0, 0);            // variable latency
    run_job(1, 3, rnd256(), 4, 4, 1'b1, 0);              // start while busy
    run_job(7, 2, rnd256(), 2, 1, 1'b0, 0);              // back-to-back pair
    run_job(15, 1, rnd256(), 1, 1, 1'b0, 0);             // top position clamps to zero steps

    // Spurious f_done in IDLE.
    spur_req = 1'b1;
    @(negedge clk);
    spur_req = 1'b0;
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("spur_no_activity", 256'(n_done), 256'(0));
    chk("spur_data_hold", data_out, last_out);

    // Reset during the second WAIT.
    run_job(2, 6, rnd256(), 5, 5, 1'b0, 2);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    chk("abort_f_start", 256'(f_start), 256'(0));
    chk("abort_data_out", data_out, 256'(0));
    reset = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("abort_late_f_done", 256'(n_done), 256'(0));
    run_job(2, 6, rnd256(), 2, 1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
